cw_pipe: RTL and testbench

- Control-word pipeline immediately downstream of the ID-stage control decoder.
- Latches the decoded lc3b_control_word plus destination register at the ID/EX boundary and carries the ex/mem/wb sub-words through EX, MEM and WB.
- Generates load-use bubbles, branch squashes and global memory stalls.
- Owns the single data-memory port request, shared between MEM-stage and WB-stage (LDI/STI second) accesses.

---
 rtl/lc3b_types.sv | 50 +++++
 rtl/cw_hazard_unit.sv | 56 +++++
 rtl/cw_pipe.sv | 162 ++++++++++++++++
 tb/tb_cw_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, ALU ops and the decoded control word
// split into the sub-words consumed by EX, MEM and WB.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [3:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;

    typedef struct packed {
        lc3b_aluop  aluop;
        logic       sr2mux_sel;
        logic [1:0] pcmux_sel;
    } lc3b_ex_cw;

    typedef struct packed {
        logic d_mem_read;
        logic d_mem_write;
        logic mem_byte;
    } lc3b_mem_cw;

    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic       d_mem_read;
        logic       d_mem_write;
        logic [1:0] regfilemux_sel;
    } lc3b_wb_cw;

    typedef struct packed {
        lc3b_ex_cw  ex;
        lc3b_mem_cw mem;
        lc3b_wb_cw  wb;
    } lc3b_control_word;

    typedef struct packed {
        lc3b_mem_cw mem;
        lc3b_wb_cw  wb;
    } lc3b_mem_stage_cw;

    // Used for reset and for every bubble injected into a stage.
    localparam lc3b_control_word NOP_CW = '{
        ex:  '{aluop: alu_pass, sr2mux_sel: 1'b0, pcmux_sel: 2'b00},
        mem: '{d_mem_read: 1'b0, d_mem_write: 1'b0, mem_byte: 1'b0},
        wb:  '{load_regfile: 1'b0, load_cc: 1'b0, d_mem_read: 1'b0,
               d_mem_write: 1'b0, regfilemux_sel: 2'b00}
    };

endpackage

// File: rtl/cw_hazard_unit.sv
// Combinational hazard logic: load-use detection, data-port arbitration between the
// MEM and WB stages, and the resulting per-stage holds and global stall.
module cw_hazard_unit
    import lc3b_types::*;
#(
    parameter bit LOAD_USE_EN = 1'b1,
    parameter bit WB_PRIORITY = 1'b1
) (
    input  logic    valid_id,
    input  lc3b_reg sr1_id,
    input  lc3b_reg sr2_id,
    input  logic    sr1_used,
    input  logic    sr2_used,
    input  logic    valid_ex,
    input  logic    ex_mem_read,
    input  logic    ex_load_regfile,
    input  lc3b_reg dest_ex,
    input  logic    valid_mem,
    input  logic    mem_rd,
    input  logic    mem_wr,
    input  logic    valid_wb,
    input  logic    wb_rd,
    input  logic    wb_wr,
    input  logic    dmem_resp,
    output logic    luse,
    output logic    owner_wb,
    output logic    wb_need,
    output logic    wb_hold,
    output logic    mem_hold,
    output logic    stall_all
);

    logic mem_need;
    logic src_match;

    always_comb begin
        src_match = (sr1_used && (sr1_id == dest_ex)) || (sr2_used && (sr2_id == dest_ex));
        luse      = LOAD_USE_EN && valid_ex && ex_mem_read && ex_load_regfile
                    && valid_id && src_match;

        wb_need  = valid_wb && (wb_rd || wb_wr);
        mem_need = valid_mem && (mem_rd || mem_wr);

        // With no requester the owner defaults to MEM so the select idles low.
        if (wb_need && mem_need) begin
            owner_wb = WB_PRIORITY;
        end else begin
            owner_wb = wb_need;
        end

        wb_hold   = wb_need && !(owner_wb && dmem_resp);
        mem_hold  = mem_need && !(!owner_wb && dmem_resp);
        stall_all = wb_hold || mem_hold;
    end

endmodule

// File: rtl/cw_pipe.sv
// ID/EX, EX/MEM and MEM/WB control-word registers with bubble, squash and
// memory-stall handling, plus the shared data-port request.
module cw_pipe
    import lc3b_types::*;
#(
    parameter bit LOAD_USE_EN = 1'b1,
    parameter bit WB_PRIORITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  lc3b_control_word cw_id,
    input  logic             valid_id,
    input  lc3b_reg          dest_id,
    input  lc3b_reg          sr1_id,
    input  lc3b_reg          sr2_id,
    input  logic             sr1_used,
    input  logic             sr2_used,
    input  logic             flush,
    input  logic             dmem_resp,
    output lc3b_ex_cw        cw_ex_o,
    output lc3b_mem_cw       cw_mem_o,
    output lc3b_wb_cw        cw_wb_o,
    output lc3b_reg          dest_ex_o,
    output lc3b_reg          dest_mem_o,
    output lc3b_reg          dest_wb_o,
    output logic             valid_ex_o,
    output logic             valid_mem_o,
    output logic             valid_wb_o,
    output logic             stall_id_o,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic             dmem_wb_sel_o
);

    lc3b_control_word cw_ex_q, cw_ex_d;
    lc3b_mem_stage_cw cw_mem_q, cw_mem_d;
    lc3b_wb_cw        cw_wb_q, cw_wb_d;
    lc3b_reg          dest_ex_q, dest_ex_d, dest_mem_q, dest_mem_d, dest_wb_q, dest_wb_d;
    logic             valid_ex_q, valid_ex_d, valid_mem_q, valid_mem_d, valid_wb_q, valid_wb_d;

    logic luse, owner_wb, wb_need, wb_hold, mem_hold, stall_all;

    cw_hazard_unit #(
        .LOAD_USE_EN(LOAD_USE_EN),
        .WB_PRIORITY(WB_PRIORITY)
    ) u_hazard (
        .valid_id       (valid_id),
        .sr1_id         (sr1_id),
        .sr2_id         (sr2_id),
        .sr1_used       (sr1_used),
        .sr2_used       (sr2_used),
        .valid_ex       (valid_ex_q),
        .ex_mem_read    (cw_ex_q.mem.d_mem_read),
        .ex_load_regfile(cw_ex_q.wb.load_regfile),
        .dest_ex        (dest_ex_q),
        .valid_mem      (valid_mem_q),
        .mem_rd         (cw_mem_q.mem.d_mem_read),
        .mem_wr         (cw_mem_q.mem.d_mem_write),
        .valid_wb       (valid_wb_q),
        .wb_rd          (cw_wb_q.d_mem_read),
        .wb_wr          (cw_wb_q.d_mem_write),
        .dmem_resp      (dmem_resp),
        .luse           (luse),
        .owner_wb       (owner_wb),
        .wb_need        (wb_need),
        .wb_hold        (wb_hold),
        .mem_hold       (mem_hold),
        .stall_all      (stall_all)
    );

    always_comb begin
        cw_ex_d     = cw_ex_q;
        dest_ex_d   = dest_ex_q;
        valid_ex_d  = valid_ex_q;
        cw_mem_d    = cw_mem_q;
        dest_mem_d  = dest_mem_q;
        valid_mem_d = valid_mem_q;
        cw_wb_d     = cw_wb_q;
        dest_wb_d   = dest_wb_q;
        valid_wb_d  = valid_wb_q;

        if (!stall_all) begin
            cw_wb_d     = cw_mem_q.wb;
            dest_wb_d   = dest_mem_q;
            valid_wb_d  = valid_mem_q;
            cw_mem_d    = '{mem: cw_ex_q.mem, wb: cw_ex_q.wb};
            dest_mem_d  = dest_ex_q;
            valid_mem_d = valid_ex_q;
            if (flush || luse) begin
                cw_ex_d    = NOP_CW;
                dest_ex_d  = '0;
                valid_ex_d = 1'b0;
            end else begin
                cw_ex_d    = cw_id;
                dest_ex_d  = dest_id;
                valid_ex_d = valid_id;
            end
        end else begin
            // A finished WB access retires even while MEM waits, otherwise a WB-priority
            // port would never be released to the instruction behind it.
            if (wb_need && !wb_hold) begin
                cw_wb_d    = NOP_CW.wb;
                dest_wb_d  = '0;
                valid_wb_d = 1'b0;
            end
            if (flush) begin
                cw_ex_d    = NOP_CW;
                dest_ex_d  = '0;
                valid_ex_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_ex_q     <= NOP_CW;
            cw_mem_q    <= '{mem: NOP_CW.mem, wb: NOP_CW.wb};
            cw_wb_q     <= NOP_CW.wb;
            dest_ex_q   <= '0;
            dest_mem_q  <= '0;
            dest_wb_q   <= '0;
            valid_ex_q  <= 1'b0;
            valid_mem_q <= 1'b0;
            valid_wb_q  <= 1'b0;
        end else begin
            cw_ex_q     <= cw_ex_d;
            cw_mem_q    <= cw_mem_d;
            cw_wb_q     <= cw_wb_d;
            dest_ex_q   <= dest_ex_d;
            dest_mem_q  <= dest_mem_d;
            dest_wb_q   <= dest_wb_d;
            valid_ex_q  <= valid_ex_d;
            valid_mem_q <= valid_mem_d;
            valid_wb_q  <= valid_wb_d;
        end
    end

    always_comb begin
        cw_ex_o               = cw_ex_q.ex;
        cw_mem_o              = cw_mem_q.mem;
        cw_mem_o.d_mem_read   = cw_mem_q.mem.d_mem_read & valid_mem_q;
        cw_mem_o.d_mem_write  = cw_mem_q.mem.d_mem_write & valid_mem_q;
        cw_wb_o               = cw_wb_q;
        cw_wb_o.load_regfile  = cw_wb_q.load_regfile & valid_wb_q;
        cw_wb_o.load_cc       = cw_wb_q.load_cc & valid_wb_q;
        cw_wb_o.d_mem_read    = cw_wb_q.d_mem_read & valid_wb_q;
        cw_wb_o.d_mem_write   = cw_wb_q.d_mem_write & valid_wb_q;
        dest_ex_o             = dest_ex_q;
        dest_mem_o            = dest_mem_q;
        dest_wb_o             = dest_wb_q;
        valid_ex_o            = valid_ex_q;
        valid_mem_o           = valid_mem_q;
        valid_wb_o            = valid_wb_q;
        stall_id_o            = stall_all | (luse & ~flush);
        dmem_wb_sel_o         = owner_wb;
        dmem_read_o  = owner_wb ? (valid_wb_q & cw_wb_q.d_mem_read)
                                : (valid_mem_q & cw_mem_q.mem.d_mem_read);
        dmem_write_o = owner_wb ? (valid_wb_q & cw_wb_q.d_mem_write)
                                : (valid_mem_q & cw_mem_q.mem.d_mem_write);
    end

endmodule

// File: tb/tb_cw_pipe.sv
// Directed bench for cw_pipe: straight-line steps with hand-computed expectations,
// plus a second instance built without load-use detection.
module tb_cw_pipe;
    import lc3b_types::*;

    logic             clk = 1'b0;
    logic             rst;
    lc3b_control_word cw_id;
    logic             valid_id, sr1_used, sr2_used, flush, dmem_resp;
    lc3b_reg          dest_id, sr1_id, sr2_id;

    lc3b_ex_cw  cw_ex_o, nl_cw_ex_o;
    lc3b_mem_cw cw_mem_o, nl_cw_mem_o;
    lc3b_wb_cw  cw_wb_o, nl_cw_wb_o;
    lc3b_reg    dest_ex_o, dest_mem_o, dest_wb_o, nl_dest_ex_o, nl_dest_mem_o, nl_dest_wb_o;
    logic       valid_ex_o, valid_mem_o, valid_wb_o, stall_id_o;
    logic       dmem_read_o, dmem_write_o, dmem_wb_sel_o;
    logic       nl_valid_ex_o, nl_valid_mem_o, nl_valid_wb_o, nl_stall_id_o;
    logic       nl_dmem_read_o, nl_dmem_write_o, nl_dmem_wb_sel_o;

    int n_vec  = 0;
    int n_miss = 0;

    lc3b_control_word cw_add, cw_and, cw_not, cw_ldr, cw_sti;

    always #5 clk = ~clk;

    cw_pipe dut (
        .clk(clk), .rst(rst), .cw_id(cw_id), .valid_id(valid_id), .dest_id(dest_id),
        .sr1_id(sr1_id), .sr2_id(sr2_id), .sr1_used(sr1_used), .sr2_used(sr2_used),
        .flush(flush), .dmem_resp(dmem_resp),
        .cw_ex_o(cw_ex_o), .cw_mem_o(cw_mem_o), .cw_wb_o(cw_wb_o),
        .dest_ex_o(dest_ex_o), .dest_mem_o(dest_mem_o), .dest_wb_o(dest_wb_o),
        .valid_ex_o(valid_ex_o), .valid_mem_o(valid_mem_o), .valid_wb_o(valid_wb_o),
        .stall_id_o(stall_id_o), .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .dmem_wb_sel_o(dmem_wb_sel_o)
    );

    cw_pipe #(.LOAD_USE_EN(1'b0), .WB_PRIORITY(1'b1)) dut_nl (
        .clk(clk), .rst(rst), .cw_id(cw_id), .valid_id(valid_id), .dest_id(dest_id),
        .sr1_id(sr1_id), .sr2_id(sr2_id), .sr1_used(sr1_used), .sr2_used(sr2_used),
        .flush(flush), .dmem_resp(dmem_resp),
        .cw_ex_o(nl_cw_ex_o), .cw_mem_o(nl_cw_mem_o), .cw_wb_o(nl_cw_wb_o),
        .dest_ex_o(nl_dest_ex_o), .dest_mem_o(nl_dest_mem_o), .dest_wb_o(nl_dest_wb_o),
        .valid_ex_o(nl_valid_ex_o), .valid_mem_o(nl_valid_mem_o), .valid_wb_o(nl_valid_wb_o),
        .stall_id_o(nl_stall_id_o), .dmem_read_o(nl_dmem_read_o),
        .dmem_write_o(nl_dmem_write_o), .dmem_wb_sel_o(nl_dmem_wb_sel_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input lc3b_control_word cw, input lc3b_reg d,
                          input lc3b_reg s1, input logic u1, input lc3b_reg s2, input logic u2);
        valid_id = v;
        cw_id    = cw;
        dest_id  = d;
        sr1_id   = s1;
        sr1_used = u1;
        sr2_id   = s2;
        sr2_used = u2;
    endtask

    initial begin
        cw_add = NOP_CW; cw_add.ex.aluop = alu_add; cw_add.wb.load_regfile = 1'b1; cw_add.wb.load_cc = 1'b1;
        cw_and = cw_add; cw_and.ex.aluop = alu_and;
        cw_not = cw_add; cw_not.ex.aluop = alu_not;
        cw_ldr = NOP_CW; cw_ldr.mem.d_mem_read = 1'b1; cw_ldr.wb.load_regfile = 1'b1;
        cw_ldr.wb.load_cc = 1'b1; cw_ldr.wb.regfilemux_sel = 2'b01;
        cw_sti = NOP_CW; cw_sti.mem.d_mem_read = 1'b1; cw_sti.wb.d_mem_write = 1'b1;

        rst = 1'b1; flush = 1'b0; dmem_resp = 1'b0;
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick(); tick();
        @(negedge clk);
        check("rst_valid", {valid_ex_o, valid_mem_o, valid_wb_o}, 3'b000);
        check("rst_stall", stall_id_o, 1'b0);
        check("rst_dmem", {dmem_read_o, dmem_write_o}, 2'b00);
        check("rst_cw_ex", 32'(cw_ex_o), 32'(NOP_CW.ex));
        check("rst_cw_wb", 32'(cw_wb_o), 32'(NOP_CW.wb));
        check("rst_dest", {dest_ex_o, dest_mem_o, dest_wb_o}, 9'd0);
        tick();
        rst = 1'b0;

        // ADD R1, AND R2, NOT R3 flowing back-to-back.
        set_id(1'b1, cw_add, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b1, cw_and, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("t1_ex_add", {valid_ex_o, 1'b0, dest_ex_o}, {1'b1, 1'b0, 3'd1});
        check("t1_ex_aluop", 32'(cw_ex_o.aluop), 32'(alu_add));
        check("t1_stall0", stall_id_o, 1'b0);
        tick();
        set_id(1'b1, cw_not, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("t1_ex_and", 32'(cw_ex_o.aluop), 32'(alu_and));
        check("t1_mem_add", {valid_mem_o, dest_mem_o}, {1'b1, 3'd1});
        tick();
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("t1_wb_add", {valid_wb_o, dest_wb_o, cw_wb_o.load_regfile}, {1'b1, 3'd1, 1'b1});
        check("t1_ex_not", {valid_ex_o, dest_ex_o}, {1'b1, 3'd3});
        tick();
        @(negedge clk);
        check("t1_wb_and", {valid_wb_o, dest_wb_o}, {1'b1, 3'd2});
        check("t1_stall1", stall_id_o, 1'b0);
        tick();
        @(negedge clk);
        check("t1_wb_not", {valid_wb_o, dest_wb_o}, {1'b1, 3'd3});
        tick();
        @(negedge clk);
        check("t1_wb_done", {valid_wb_o, cw_wb_o.load_regfile}, 2'b00);

        // LDR R4 then dependent ADD R5,R4,R1: one bubble only with detection on.
        set_id(1'b1, cw_ldr, 3'd4, 3'd0, 1'b1, 3'd0, 1'b0);
        tick();
        set_id(1'b1, cw_add, 3'd5, 3'd4, 1'b1, 3'd1, 1'b1);
        @(negedge clk);
        check("t2_luse_stall", stall_id_o, 1'b1);
        check("t2_nl_nostall", nl_stall_id_o, 1'b0);
        tick();
        dmem_resp = 1'b1;
        @(negedge clk);
        check("t2_bubble", valid_ex_o, 1'b0);
        check("t2_stall_gone", stall_id_o, 1'b0);
        check("t2_ldr_read", {dmem_read_o, dmem_wb_sel_o}, 2'b10);
        check("t2_nl_ex_add", {nl_valid_ex_o, nl_dest_ex_o}, {1'b1, 3'd5});
        tick();
        dmem_resp = 1'b0;
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("t2_ex_add", {valid_ex_o, dest_ex_o}, {1'b1, 3'd5});
        check("t2_mem_bubble", valid_mem_o, 1'b0);
        check("t2_wb_ldr", {valid_wb_o, dest_wb_o}, {1'b1, 3'd4});
        tick(); tick(); tick();

        // LDR R6 waits three cycles for its read; ADD R7 behind it freezes in EX.
        set_id(1'b1, cw_ldr, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b1, cw_add, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_wait_req", {dmem_read_o, dmem_write_o, dmem_wb_sel_o}, 3'b100);
            check("t3_wait_stall", stall_id_o, 1'b1);
            check("t3_frozen", {valid_ex_o, dest_ex_o, valid_mem_o, dest_mem_o},
                  {1'b1, 3'd7, 1'b1, 3'd6});
            tick();
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        check("t3_resp_req", dmem_read_o, 1'b1);
        check("t3_resp_stall", stall_id_o, 1'b0);
        tick();
        dmem_resp = 1'b0;
        @(negedge clk);
        check("t3_adv", {valid_ex_o, valid_mem_o, dest_mem_o, valid_wb_o, dest_wb_o},
              {1'b0, 1'b1, 3'd7, 1'b1, 3'd6});
        check("t3_idle", dmem_read_o, 1'b0);
        tick(); tick();

        // STI then LDR R2: MEM read, WB write with LDR parked in MEM, then LDR read.
        set_id(1'b1, cw_sti, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b1, cw_ldr, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("t4_sti_rd", {dmem_read_o, dmem_write_o, dmem_wb_sel_o, stall_id_o}, 4'b1001);
        tick();
        dmem_resp = 1'b1;
        @(negedge clk);
        check("t4_sti_rd_resp", {dmem_read_o, dmem_wb_sel_o}, 2'b10);
        tick();
        dmem_resp = 1'b0;
        @(negedge clk);
        check("t4_sti_wr", {dmem_read_o, dmem_write_o, dmem_wb_sel_o, stall_id_o}, 4'b0111);
        check("t4_ldr_parked", {valid_mem_o, dest_mem_o, valid_wb_o}, {1'b1, 3'd2, 1'b1});
        tick();
        dmem_resp = 1'b1;
        @(negedge clk);
        check("t4_sti_wr_resp", {dmem_write_o, dmem_wb_sel_o, stall_id_o}, 3'b111);
        tick();
        dmem_resp = 1'b0;
        @(negedge clk);
        check("t4_ldr_rd", {dmem_read_o, dmem_write_o, dmem_wb_sel_o}, 3'b100);
        check("t4_sti_retired", {valid_wb_o, valid_mem_o, dest_mem_o}, {1'b0, 1'b1, 3'd2});
        tick();
        dmem_resp = 1'b1;
        @(negedge clk);
        check("t4_ldr_rd_resp", {dmem_read_o, stall_id_o}, 2'b10);
        tick();
        dmem_resp = 1'b0;
        @(negedge clk);
        check("t4_ldr_wb", {valid_wb_o, dest_wb_o, dmem_read_o}, {1'b1, 3'd2, 1'b0});
        tick(); tick();

        // Flush with ADD R3 in EX and ADD R4 in ID.
        set_id(1'b1, cw_add, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b1, cw_add, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("t5_flush_nostall", stall_id_o, 1'b0);
        tick();
        flush = 1'b0;
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("t5_ex_squash", {valid_ex_o, valid_mem_o, dest_mem_o}, {1'b0, 1'b1, 3'd3});
        tick();
        @(negedge clk);
        check("t5_id_dropped", {valid_mem_o, valid_wb_o, dest_wb_o}, {1'b0, 1'b1, 3'd3});
        tick();

        // Flush during a memory stall squashes EX in place.
        set_id(1'b1, cw_ldr, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b1, cw_add, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("t5_stall_flush", {stall_id_o, valid_ex_o, dest_ex_o}, {1'b1, 1'b1, 3'd6});
        tick();
        flush = 1'b0;
        dmem_resp = 1'b1;
        @(negedge clk);
        check("t5_squash_inplace", {valid_ex_o, valid_mem_o, dest_mem_o}, {1'b0, 1'b1, 3'd5});
        tick();
        dmem_resp = 1'b0;
        @(negedge clk);
        check("t5_after_stall", {valid_mem_o, valid_wb_o, dest_wb_o}, {1'b0, 1'b1, 3'd5});
        tick(); tick();

        // Reset in the middle of an outstanding read.
        set_id(1'b1, cw_ldr, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_id(1'b0, NOP_CW, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        @(negedge clk);
        check("t6_inflight", dmem_read_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_resp = 1'b1;
        @(negedge clk);
        check("t6_rst_clear", {valid_ex_o, valid_mem_o, valid_wb_o, dmem_read_o}, 4'b0000);
        tick();
        dmem_resp = 1'b0;
        @(negedge clk);
        check("t6_late_resp", {valid_ex_o, valid_mem_o, valid_wb_o, dmem_read_o, stall_id_o},
              5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
